// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: operand forwarding,
// load-use bubbles, branch flushes, data-memory wait freeze and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pipe_hold,
    output logic             pc_sel_branch,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_d;
    logic              load_use;
    logic              mem_stall;

    assign load_use  = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_stall = dmem_req && !dmem_ready;

    // EX/MEM result is younger than MEM/WB, so it wins when both match; x0 never forwards.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) begin
            forward_a = 2'b10;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
            forward_a = 2'b01;
        end
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) begin
            forward_b = 2'b10;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
            forward_b = 2'b01;
        end
        if (reset) begin
            forward_a = 2'b00;
            forward_b = 2'b00;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        pipe_hold     = 1'b0;
        pc_sel_branch = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = mem_timeout;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pipe_hold   = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_d     = MEM_WAIT;
                    wait_cnt_d  = WAIT_W'(1);
                end else if (mem_branch_taken) begin
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                    state_d       = FLUSH;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                pipe_hold   = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_cnt_q < WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            // ID/EX holds a NOP here, so load-use detection is deliberately ignored.
            FLUSH: state_d = RUN;
            default: state_d = RUN;
        endcase

        if ((state_d == MEM_WAIT) && (wait_cnt_d == WAIT_MAX)) begin
            timeout_d = 1'b1;
        end

        if (reset) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_bubble  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_flush  = 1'b0;
            pipe_hold     = 1'b0;
            pc_sel_branch = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_timeout <= timeout_d;
            if (!pc_write && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ex_mem_flush && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
    //  pipe_hold, pc_sel_branch, mem_timeout}
    localparam logic [8:0] IDLE     = 9'b110000000;
    localparam logic [8:0] LU       = 9'b001000000;
    localparam logic [8:0] BR       = 9'b110111010;
    localparam logic [8:0] HOLD     = 9'b000000100;
    localparam logic [8:0] HOLD_TMO = 9'b000000101;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_memread, mem_regwrite, wb_regwrite, mem_branch_taken, dmem_req, dmem_ready;
    logic [1:0] forward_a, forward_b;
    logic pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush;
    logic pipe_hold, pc_sel_branch, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipeline_hazard_ctrl #(
        .CNT_W       (CNT_W),
        .WAIT_TIMEOUT(4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .mem_rd          (mem_rd),
        .mem_regwrite    (mem_regwrite),
        .wb_rd           (wb_rd),
        .wb_regwrite     (wb_regwrite),
        .mem_branch_taken(mem_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .pipe_hold       (pipe_hold),
        .pc_sel_branch   (pc_sel_branch),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic [8:0] ctl, input int st, input int fl);
        return {fa, fb, ctl, st[CNT_W-1:0], fl[CNT_W-1:0]};
    endfunction

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs are already applied; queue the expectation for this cycle and advance.
    task automatic step(input string name, input logic [20:0] e);
        exp_t item;
        item.name = name;
        item.exp  = e;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares mid-cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t item;
                logic [20:0] act;
                item = sb_q.pop_front();
                act = {forward_a, forward_b, pc_write, if_id_write, id_ex_bubble, if_id_flush,
                       id_ex_flush, ex_mem_flush, pipe_hold, pc_sel_branch, mem_timeout,
                       stall_cycles, flush_events};
                n_checks++;
                if (act === item.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %b required %b", item.name, act, item.exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        step("reset", ev(2'b00, 2'b00, IDLE, 0, 0));
        reset = 1'b0;
        step("idle", ev(2'b00, 2'b00, IDLE, 0, 0));

        // Forwarding priority and x0 exclusion
        mem_regwrite = 1'b1; mem_rd = 5'd5; wb_regwrite = 1'b1; wb_rd = 5'd5;
        ex_rs1 = 5'd5; ex_rs2 = 5'd3;
        step("fwd_exmem", ev(2'b10, 2'b00, IDLE, 0, 0));
        mem_rd = 5'd0;
        step("fwd_memwb", ev(2'b01, 2'b00, IDLE, 0, 0));
        wb_rd = 5'd0;
        step("fwd_x0", ev(2'b00, 2'b00, IDLE, 0, 0));
        mem_rd = 5'd5; wb_rd = 5'd6; ex_rs1 = 5'd6; ex_rs2 = 5'd5;
        step("fwd_split", ev(2'b01, 2'b10, IDLE, 0, 0));
        mem_regwrite = 1'b0; wb_rd = 5'd5; ex_rs1 = 5'd5;
        step("fwd_no_regwrite", ev(2'b01, 2'b01, IDLE, 0, 0));
        clear_inputs();

        // Load-use bubble for one cycle
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
        step("load_use", ev(2'b00, 2'b00, LU, 0, 0));
        clear_inputs();
        mem_regwrite = 1'b1; mem_rd = 5'd7; ex_rs2 = 5'd7;
        step("lu_release", ev(2'b00, 2'b10, IDLE, 1, 0));
        clear_inputs();

        // Branch beats load-use; LU masked in FLUSH, then handled in RUN
        mem_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        step("branch", ev(2'b00, 2'b00, BR, 1, 0));
        mem_branch_taken = 1'b0;
        step("flush_mask", ev(2'b00, 2'b00, IDLE, 1, 1));
        step("lu_after_flush", ev(2'b00, 2'b00, LU, 1, 1));
        clear_inputs();
        step("post_lu", ev(2'b00, 2'b00, IDLE, 2, 1));

        reset = 1'b1;
        step("reset2", ev(2'b00, 2'b00, IDLE, 0, 0));
        reset = 1'b0;

        // Memory wait: 3 cycles not ready, then ready
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step("mw_enter", ev(2'b00, 2'b00, HOLD, 0, 0));
        step("mw_1", ev(2'b00, 2'b00, HOLD, 1, 0));
        step("mw_2", ev(2'b00, 2'b00, HOLD, 2, 0));
        dmem_ready = 1'b1;
        step("mw_ready", ev(2'b00, 2'b00, HOLD, 3, 0));
        dmem_req = 1'b0; dmem_ready = 1'b0;
        step("mw_release", ev(2'b00, 2'b00, IDLE, 4, 0));

        // Same with a taken branch pending throughout
        mem_branch_taken = 1'b1; dmem_req = 1'b1;
        step("mwb_enter", ev(2'b00, 2'b00, HOLD, 4, 0));
        step("mwb_1", ev(2'b00, 2'b00, HOLD, 5, 0));
        step("mwb_2", ev(2'b00, 2'b00, HOLD, 6, 0));
        dmem_ready = 1'b1;
        step("mwb_ready", ev(2'b00, 2'b00, HOLD, 7, 0));
        dmem_req = 1'b0; dmem_ready = 1'b0;
        step("mwb_branch", ev(2'b00, 2'b00, BR, 8, 0));
        mem_branch_taken = 1'b0;
        step("mwb_flush", ev(2'b00, 2'b00, IDLE, 8, 1));

        reset = 1'b1;
        step("reset3", ev(2'b00, 2'b00, IDLE, 0, 0));
        reset = 1'b0;

        // Timeout after 4 wait cycles, then stall counter saturation at 15
        dmem_req = 1'b1; dmem_ready = 1'b0;
        step("to_enter", ev(2'b00, 2'b00, HOLD, 0, 0));
        step("to_w1", ev(2'b00, 2'b00, HOLD, 1, 0));
        step("to_w2", ev(2'b00, 2'b00, HOLD, 2, 0));
        step("to_w3", ev(2'b00, 2'b00, HOLD, 3, 0));
        step("to_w4", ev(2'b00, 2'b00, HOLD_TMO, 4, 0));
        for (int i = 5; i <= 14; i++) begin
            step("to_sticky", ev(2'b00, 2'b00, HOLD_TMO, i, 0));
        end
        step("sat_1", ev(2'b00, 2'b00, HOLD_TMO, 15, 0));
        step("sat_2", ev(2'b00, 2'b00, HOLD_TMO, 15, 0));
        step("sat_3", ev(2'b00, 2'b00, HOLD_TMO, 15, 0));

        // Reset raised mid-cycle: must take effect before the next clock edge
        reset = 1'b1;
        step("async_reset", ev(2'b00, 2'b00, IDLE, 0, 0));
        clear_inputs();
        reset = 1'b0;
        step("post_reset", ev(2'b00, 2'b00, IDLE, 0, 0));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
